fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
// One outstanding request; responses return in order at least one cycle after grant.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage with a single-outstanding imem request, a one-entry stall buffer
// and the Fetch/Decode pipeline register.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PCSrcE_i,
    input  logic [XLEN-1:0]      PCTargetE_i,
    input  logic                 StallD_i,
    input  logic                 FlushD_i,
    fetch_unit_if.master         imem,
    output logic [31:0]          InstrD_o,
    output logic [XLEN-1:0]      PCD_o,
    output logic [XLEN-1:0]      PCPlus4D_o,
    output logic                 ValidD_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [31:0]     buf_q, buf_d;
    logic            deliver;
    logic [31:0]     dword;
    logic [XLEN-1:0] pcf_plus4;

    assign pcf_plus4      = pcf_q + XLEN'(4);
    assign imem.imem_addr = pcf_q;

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        buf_d         = buf_q;
        deliver       = 1'b0;
        dword         = imem.imem_rdata;
        imem.imem_req = 1'b0;

        unique case (state_q)
            S_REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (StallD_i) begin
                        buf_d   = imem.imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!StallD_i) begin
                    deliver = 1'b1;
                    dword   = buf_q;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem.imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (deliver) pcf_d = pcf_plus4;

        // A redirect drops whatever is in flight; only an unanswered request needs draining.
        if (PCSrcE_i) begin
            deliver = 1'b0;
            pcf_d   = PCTargetE_i & ~XLEN'(3);
            unique case (state_q)
                S_REQ:     state_d = imem.imem_gnt    ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = imem.imem_rvalid ? S_REQ     : S_DISCARD;
                S_HOLD:    state_d = S_REQ;
                S_DISCARD: state_d = imem.imem_rvalid ? S_REQ     : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pcf_q   <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            buf_q   <= buf_d;
        end
    end

    // Flush beats stall beats delivery; an idle unstalled cycle inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD_o   <= NOP_INSTR;
            PCD_o      <= '0;
            PCPlus4D_o <= '0;
            ValidD_o   <= 1'b0;
        end else if (FlushD_i) begin
            InstrD_o <= NOP_INSTR;
            ValidD_o <= 1'b0;
        end else if (!StallD_i) begin
            if (deliver) begin
                InstrD_o   <= dword;
                PCD_o      <= pcf_q;
                PCPlus4D_o <= pcf_plus4;
                ValidD_o   <= 1'b1;
            end else begin
                InstrD_o <= NOP_INSTR;
                ValidD_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFC),
// each with a small latency-programmable memory answering rdata = 0xA0 + addr.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrcE, StallD, FlushD;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD0, PCD0, PC4D0;
    logic        ValidD0;
    logic [31:0] InstrD1, PCD1, PC4D1;
    logic        ValidD1;
    logic        gnt_en;
    int          lat;
    int          n_chk, n_err;

    fetch_unit_if #(.XLEN(32)) bus0 ();
    fetch_unit_if #(.XLEN(32)) bus1 ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst),
        .PCSrcE_i(PCSrcE), .PCTargetE_i(PCTargetE),
        .StallD_i(StallD), .FlushD_i(FlushD),
        .imem(bus0),
        .InstrD_o(InstrD0), .PCD_o(PCD0), .PCPlus4D_o(PC4D0), .ValidD_o(ValidD0)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst),
        .PCSrcE_i(1'b0), .PCTargetE_i(32'h0),
        .StallD_i(1'b0), .FlushD_i(1'b0),
        .imem(bus1),
        .InstrD_o(InstrD1), .PCD_o(PCD1), .PCPlus4D_o(PC4D1), .ValidD_o(ValidD1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for dut0: grant gated by gnt_en, response lat cycles after grant.
    logic        m0_pend;
    logic [31:0] m0_addr;
    int          m0_cnt;
    assign bus0.imem_gnt    = gnt_en;
    assign bus0.imem_rvalid = m0_pend && (m0_cnt == 0);
    assign bus0.imem_rdata  = 32'hA0 + m0_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_pend <= 1'b0;
            m0_addr <= '0;
            m0_cnt  <= 0;
        end else if (bus0.imem_req && bus0.imem_gnt) begin
            m0_pend <= 1'b1;
            m0_addr <= bus0.imem_addr;
            m0_cnt  <= lat - 1;
        end else if (m0_pend) begin
            if (m0_cnt == 0) m0_pend <= 1'b0;
            else             m0_cnt  <= m0_cnt - 1;
        end
    end

    // Memory for dut1: zero-wait, always granting.
    logic        m1_pend;
    logic [31:0] m1_addr;
    assign bus1.imem_gnt    = 1'b1;
    assign bus1.imem_rvalid = m1_pend;
    assign bus1.imem_rdata  = 32'hA0 + m1_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_pend <= 1'b0;
            m1_addr <= '0;
        end else if (bus1.imem_req) begin
            m1_pend <= 1'b1;
            m1_addr <= bus1.imem_addr;
        end else begin
            m1_pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b0; gnt_en = 1'b0; lat = 1;
        PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;

        // Asynchronous reset values, before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_instr", InstrD0, 32'h13);
        chk("rst_valid", ValidD0, 0);
        chk("rst_pcd",   PCD0, 0);
        chk("rst_pc4",   PC4D0, 0);
        chk("rst_req",   bus0.imem_req, 1);
        chk("rst_addr",  bus0.imem_addr, 0);
        chk("rst_addr1", bus1.imem_addr, 32'hFFFF_FFFC);

        @(posedge clk); #1 rst = 1'b0;
        chk("rel_req",  bus0.imem_req, 1);
        chk("rel_addr", bus0.imem_addr, 0);

        // No grant: request persists at the same address
        tick();
        chk("nogt_req",  bus0.imem_req, 1);
        chk("nogt_addr", bus0.imem_addr, 0);
        gnt_en = 1'b1;

        // dut1 delivers its wrap-around fetch; dut0 is waiting
        tick();
        chk("wrap_pcd",   PCD1, 32'hFFFF_FFFC);
        chk("wrap_pc4",   PC4D1, 0);
        chk("wrap_instr", InstrD1, 32'h9C);
        chk("wrap_valid", ValidD1, 1);
        chk("wrap_addr",  bus1.imem_addr, 0);
        chk("w0_req",     bus0.imem_req, 0);

        // Zero-wait streaming: delivery every second cycle
        tick();
        chk("z0_instr", InstrD0, 32'hA0);
        chk("z0_pcd",   PCD0, 0);
        chk("z0_pc4",   PC4D0, 4);
        chk("z0_valid", ValidD0, 1);
        chk("z0_addr",  bus0.imem_addr, 4);
        tick();
        chk("zb_valid", ValidD0, 0);
        chk("zb_instr", InstrD0, 32'h13);
        chk("zb_pcd",   PCD0, 0);
        tick();
        chk("z4_pcd",   PCD0, 4);
        chk("z4_instr", InstrD0, 32'hA4);
        tick(); tick();
        chk("z8_pcd",   PCD0, 8);
        chk("z8_pc4",   PC4D0, 32'hC);
        chk("z8_valid", ValidD0, 1);
        tick(); tick();
        chk("zc_pcd", PCD0, 32'hC);

        // Stall across the 0x10 response
        tick();
        StallD = 1'b1;
        tick(); tick(); tick();
        chk("hold_req",   bus0.imem_req, 0);
        chk("hold_valid", ValidD0, 0);
        chk("hold_instr", InstrD0, 32'h13);
        chk("hold_pcd",   PCD0, 32'hC);
        StallD = 1'b0;
        tick();
        chk("stl_pcd",   PCD0, 32'h10);
        chk("stl_instr", InstrD0, 32'hB0);
        chk("stl_valid", ValidD0, 1);
        chk("stl_pc4",   PC4D0, 32'h14);
        chk("stl_addr",  bus0.imem_addr, 32'h14);
        chk("stl_req",   bus0.imem_req, 1);

        // Redirect while a slow response is pending
        lat = 3;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        tick();
        PCSrcE = 1'b0;
        chk("rd_req",   bus0.imem_req, 0);
        chk("rd_addr",  bus0.imem_addr, 32'h100);
        chk("rd_valid", ValidD0, 0);
        tick();
        chk("rd_late_req", bus0.imem_req, 0);
        tick();
        chk("rd_drop_valid", ValidD0, 0);
        chk("rd_drop_pcd",   PCD0, 32'h10);
        chk("rd_drop_req",   bus0.imem_req, 1);
        chk("rd_drop_addr",  bus0.imem_addr, 32'h100);
        lat = 1;
        tick(); tick();
        chk("rd_pcd",   PCD0, 32'h100);
        chk("rd_instr", InstrD0, 32'h1A0);
        chk("rd_valid2", ValidD0, 1);
        chk("rd_pc4",   PC4D0, 32'h104);

        // Redirect + flush (with stall) in the rvalid cycle
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h200; FlushD = 1'b1; StallD = 1'b1;
        tick();
        PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
        chk("fl_instr", InstrD0, 32'h13);
        chk("fl_valid", ValidD0, 0);
        chk("fl_pcd",   PCD0, 32'h100);
        chk("fl_req",   bus0.imem_req, 1);
        chk("fl_addr",  bus0.imem_addr, 32'h200);
        tick(); tick();
        chk("fl_next_pcd",   PCD0, 32'h200);
        chk("fl_next_instr", InstrD0, 32'h2A0);
        chk("fl_next_valid", ValidD0, 1);

        // Reset pulsed mid-WAIT
        lat = 3;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("ar_instr", InstrD0, 32'h13);
        chk("ar_valid", ValidD0, 0);
        chk("ar_pcd",   PCD0, 0);
        chk("ar_pc4",   PC4D0, 0);
        chk("ar_req",   bus0.imem_req, 1);
        chk("ar_addr",  bus0.imem_addr, 0);
        @(posedge clk); #1 rst = 1'b0; lat = 1;
        chk("ar_rel_req",  bus0.imem_req, 1);
        chk("ar_rel_addr", bus0.imem_addr, 0);
        tick(); tick();
        chk("ar_pcd2",  PCD0, 0);
        chk("ar_instr2", InstrD0, 32'hA0);
        chk("ar_valid2", ValidD0, 1);
        chk("ar_pc42",  PC4D0, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
